arduino_bus_arbiter: RTL and testbench
======================================

Name: arduino_bus_arbiter

Overview:
Round-robin arbiter that shares the single 4-bit hub output bus ({address, data}) among several Arduino nodes. Each node raises a request with a 2-bit payload. The arbiter grants one node at a time, drives the bus with the node index as address, and waits for a destination ack or a timeout. All sequencing advances on the slow tick from the temporizador divider, so external Arduinos see stable values.

Parameters:
NUM_NODES, 4, number of requesting nodes; must be <= 2**ADDR_W
ADDR_W, 2, address field width on bus_out
DATA_W, 2, payload width per node
TIMEOUT_TICKS, 15, ticks in HOLD without ack before abort; range 1..255

Ports:
clock50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
tick  in  1  one-clock50-cycle enable pulse from the temporizador divider; all state changes are qualified by it
req  in  NUM_NODES  per-node request level
node_data  in  NUM_NODES*DATA_W  payloads; node i occupies bits [i*DATA_W +: DATA_W]
ack  in  1  destination accepted the bus word; sampled only on tick
grant  out  NUM_NODES  one-hot grant; all zero when idle
bus_out  out  ADDR_W+DATA_W  {granted index, latched payload}
bus_valid  out  1  bus_out holds a live word
done  out  NUM_NODES  one-clock50-cycle pulse to the granted node on ack
timeout_err  out  1  one-clock50-cycle pulse on timeout abort
rr_ptr_dbg  out  ADDR_W  current round-robin pointer, debug only

Behaviour:
- Reset (async): state=IDLE; grant=0; bus_out=0; bus_valid=0; done=0; timeout_err=0; rr_ptr=0; tick counter=0.
- done and timeout_err are single-clock50 pulses, registered on the tick cycle, cleared the next cycle.
- States: IDLE, HOLD, RELEASE. No transition occurs without tick=1.
- IDLE, on tick:
  - If req != 0, select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_NODES.
  - Set grant[i]; latch bus_out={i[ADDR_W-1:0], node_data[i]}; set bus_valid=1; clear counter; go HOLD.
  - Grant is visible the cycle after that tick (latency 1 clock50).
- HOLD, on tick, in priority order:
  1. ack=1: done[i] pulses, go RELEASE.
  2. req[i]=0 (requester withdrew): go RELEASE, no done, no error.
  3. counter==TIMEOUT_TICKS-1: timeout_err pulses, go RELEASE.
  4. Otherwise counter+1.
- HOLD payload: bus_out payload stays frozen even if node_data[i] changes.
- RELEASE, on tick: grant=0, bus_valid=0, bus_out=0; rr_ptr=(i+1) mod NUM_NODES (wrap at NUM_NODES, not 2**ADDR_W); go IDLE.
  - The bus is guaranteed idle for at least one full tick period between grants.
- Simultaneous ack and withdrawal on the same tick: ack wins, done pulses.
- ack outside HOLD is ignored.
- Requests from non-granted nodes during HOLD are ignored until the next IDLE evaluation.
- Reset asserted mid-HOLD drops grant and bus_valid immediately, with no done.
- Counter is 8 bits wide; TIMEOUT_TICKS=1 aborts on the first HOLD tick without ack.

Optional Feature:
ARB_PRIORITY_EN
- Defined: node 0 is high priority. In IDLE, if req[0]=1 it is granted regardless of rr_ptr, and rr_ptr is not updated on its release. Other nodes keep round-robin order among themselves.
- Undefined: pure round-robin as above, with no special case for node 0.

Test Plan:
1. Reset then req=4'b0000 for 10 ticks -> grant=0, bus_valid=0, bus_out=4'b0000 throughout.
2. req=4'b0100, node2 data=2'b11, ack on 2nd HOLD tick -> grant=4'b0100, bus_out=4'b1011, done[2] single pulse, next IDLE rr_ptr=3.
3. req=4'b1111 held, ack on every HOLD tick -> grant order 0,1,2,3,0; bus idle one tick between each grant.
4. req=4'b0010, never ack, TIMEOUT_TICKS=15 -> timeout_err pulse on 15th HOLD tick, grant drops on the following tick, done stays 0.
5. Node1 granted, req[1] dropped and ack=1 on the same tick -> done[1] pulses; on a separate run with the drop and no ack -> no done, no error.
6. Reset pulsed mid-HOLD -> grant, bus_valid and bus_out all zero within the same clock50 cycle; with ARB_PRIORITY_EN and req=4'b1001, rr_ptr=3 -> node0 granted first.

Source files
------------

// File: rtl/arduino_bus_arbiter.sv
// Round-robin arbiter sharing the 4-bit hub bus among Arduino nodes, paced by the temporizador tick.
// Define ARB_PRIORITY_EN to make node 0 a high-priority requester that bypasses the rotation.
module arduino_bus_arbiter #(
    parameter int NUM_NODES     = 4,
    parameter int ADDR_W        = 2,
    parameter int DATA_W        = 2,
    parameter int TIMEOUT_TICKS = 15
) (
    input  logic                          clock50,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_NODES-1:0]          req,
    input  logic [NUM_NODES*DATA_W-1:0]   node_data,
    input  logic                          ack,
    output logic [NUM_NODES-1:0]          grant,
    output logic [ADDR_W+DATA_W-1:0]      bus_out,
    output logic                          bus_valid,
    output logic [NUM_NODES-1:0]          done,
    output logic                          timeout_err,
    output logic [ADDR_W-1:0]             rr_ptr_dbg
);

    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

    state_t                      state, state_next;
    logic [NUM_NODES-1:0]        grant_next, done_next;
    logic [ADDR_W+DATA_W-1:0]    bus_next;
    logic                        bus_valid_next, timeout_next;
    logic [ADDR_W-1:0]           rr_ptr, rr_next, owner, owner_next;
    logic [7:0]                  counter, counter_next;
    logic                        pick_found;
    logic [ADDR_W-1:0]           pick_idx, cand_idx;
    int                          cand;

    assign rr_ptr_dbg = rr_ptr;

    // Winner search: first requester at or after rr_ptr, wrapping at NUM_NODES.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
`ifdef ARB_PRIORITY_EN
        if (req[0]) begin
            pick_found = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_NODES; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_NODES;
            cand_idx = ADDR_W'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            bus_out     <= '0;
            bus_valid   <= 1'b0;
            done        <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            owner       <= '0;
            counter     <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            bus_out     <= bus_next;
            bus_valid   <= bus_valid_next;
            done        <= done_next;
            timeout_err <= timeout_next;
            rr_ptr      <= rr_next;
            owner       <= owner_next;
            counter     <= counter_next;
        end
    end

    // done and timeout_err default low so they last exactly one clock50 cycle.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        bus_next       = bus_out;
        bus_valid_next = bus_valid;
        done_next      = '0;
        timeout_next   = 1'b0;
        rr_next        = rr_ptr;
        owner_next     = owner;
        counter_next   = counter;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_next     = NUM_NODES'(1) << pick_idx;
                        bus_next       = {pick_idx, node_data[pick_idx*DATA_W +: DATA_W]};
                        bus_valid_next = 1'b1;
                        counter_next   = '0;
                        owner_next     = pick_idx;
                        state_next     = HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        done_next  = NUM_NODES'(1) << owner;
                        state_next = RELEASE;
                    end else if (!req[owner]) begin
                        state_next = RELEASE;
                    end else if (counter == 8'(TIMEOUT_TICKS - 1)) begin
                        timeout_next = 1'b1;
                        state_next   = RELEASE;
                    end else begin
                        counter_next = counter + 8'd1;
                    end
                end
                RELEASE: begin
                    grant_next     = '0;
                    bus_next       = '0;
                    bus_valid_next = 1'b0;
                    state_next     = IDLE;
`ifdef ARB_PRIORITY_EN
                    if (owner != '0) begin
                        rr_next = (owner == ADDR_W'(NUM_NODES - 1)) ? '0 : owner + ADDR_W'(1);
                    end
`else
                    rr_next = (owner == ADDR_W'(NUM_NODES - 1)) ? '0 : owner + ADDR_W'(1);
`endif
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arduino_bus_arbiter.sv
// Directed bench for arduino_bus_arbiter; one applyStimulus call issues exactly one tick.
module tb_arduino_bus_arbiter;

    logic       clock50 = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] req;
    logic [7:0] node_data;
    logic       ack;
    logic [3:0] grant;
    logic [3:0] bus_out;
    logic       bus_valid;
    logic [3:0] done;
    logic       timeout_err;
    logic [1:0] rr_ptr_dbg;

    int checks_total  = 0;
    int checks_passed = 0;

    arduino_bus_arbiter #(
        .NUM_NODES(4), .ADDR_W(2), .DATA_W(2), .TIMEOUT_TICKS(15)
    ) dut (
        .clock50(clock50), .reset(reset), .tick(tick), .req(req),
        .node_data(node_data), .ack(ack), .grant(grant), .bus_out(bus_out),
        .bus_valid(bus_valid), .done(done), .timeout_err(timeout_err),
        .rr_ptr_dbg(rr_ptr_dbg)
    );

    always #5 clock50 = ~clock50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change at a negedge, tick spans one posedge, sampling happens at the following negedge.
    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d, input logic a);
        @(negedge clock50);
        req       = r;
        node_data = d;
        ack       = a;
        tick      = 1'b1;
        @(negedge clock50);
        tick      = 1'b0;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        tick      = 1'b0;
        req       = '0;
        node_data = '0;
        ack       = 1'b0;
        repeat (2) @(negedge clock50);
        reset     = 1'b0;
    endtask

    logic [3:0] exp_grant;

    initial begin
        // Reset state and idle bus, stray ack ignored
        doReset();
        checkOutput("rst_grant", grant, 4'b0000);
        checkOutput("rst_bus", bus_out, 4'b0000);
        checkOutput("rst_valid", bus_valid, 1'b0);
        checkOutput("rst_done", done, 4'b0000);
        checkOutput("rst_tmo", timeout_err, 1'b0);
        checkOutput("rst_rr", rr_ptr_dbg, 2'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, 8'hFF, i[0]);
            checkOutput("idle_grant", grant, 4'b0000);
            checkOutput("idle_valid", bus_valid, 1'b0);
            checkOutput("idle_bus", bus_out, 4'b0000);
            checkOutput("idle_done", done, 4'b0000);
        end

        // Single request from node2, payload frozen, ack on second HOLD tick
        applyStimulus(4'b0100, 8'h30, 1'b0);
        checkOutput("n2_grant", grant, 4'b0100);
        checkOutput("n2_bus", bus_out, 4'b1011);
        checkOutput("n2_valid", bus_valid, 1'b1);
        applyStimulus(4'b0100, 8'h00, 1'b0);
        checkOutput("n2_frozen", bus_out, 4'b1011);
        checkOutput("n2_nodone", done, 4'b0000);
        applyStimulus(4'b0100, 8'h00, 1'b1);
        checkOutput("n2_done", done, 4'b0100);
        checkOutput("n2_hold_grant", grant, 4'b0100);
        @(negedge clock50);
        checkOutput("n2_done_pulse", done, 4'b0000);
        applyStimulus(4'b0000, 8'h00, 1'b0);
        checkOutput("n2_rel_grant", grant, 4'b0000);
        checkOutput("n2_rel_valid", bus_valid, 1'b0);
        checkOutput("n2_rel_bus", bus_out, 4'b0000);
        checkOutput("n2_rr", rr_ptr_dbg, 2'd3);

        // All nodes requesting: rotation 0,1,2,3,0 with an idle tick between grants
        doReset();
        for (int j = 0; j < 5; j++) begin
            exp_grant = 4'b0001 << (j % 4);
            applyStimulus(4'b1111, 8'hE4, 1'b0);
            checkOutput("rr_grant", grant, exp_grant);
            checkOutput("rr_bus", bus_out, {2'(j % 4), 2'(j % 4)});
            applyStimulus(4'b1111, 8'hE4, 1'b1);
            checkOutput("rr_done", done, exp_grant);
            applyStimulus(4'b1111, 8'hE4, 1'b0);
            checkOutput("rr_gap_grant", grant, 4'b0000);
            checkOutput("rr_gap_valid", bus_valid, 1'b0);
        end

        // Timeout: node1 never acked, abort on 15th HOLD tick
        doReset();
        applyStimulus(4'b0010, 8'h00, 1'b0);
        checkOutput("tmo_grant", grant, 4'b0010);
        for (int t = 1; t <= 14; t++) begin
            applyStimulus(4'b0010, 8'h00, 1'b0);
            checkOutput("tmo_early", timeout_err, 1'b0);
        end
        applyStimulus(4'b0010, 8'h00, 1'b0);
        checkOutput("tmo_pulse", timeout_err, 1'b1);
        checkOutput("tmo_nodone", done, 4'b0000);
        checkOutput("tmo_still_grant", grant, 4'b0010);
        applyStimulus(4'b0010, 8'h00, 1'b0);
        checkOutput("tmo_drop", grant, 4'b0000);
        checkOutput("tmo_pulse_end", timeout_err, 1'b0);
        checkOutput("tmo_rr", rr_ptr_dbg, 2'd2);

        // Withdrawal together with ack: ack wins
        doReset();
        applyStimulus(4'b0010, 8'h00, 1'b0);
        applyStimulus(4'b0000, 8'h00, 1'b1);
        checkOutput("wd_ack_done", done, 4'b0010);

        // Withdrawal alone: silent release
        doReset();
        applyStimulus(4'b0010, 8'h00, 1'b0);
        applyStimulus(4'b0000, 8'h00, 1'b0);
        checkOutput("wd_nodone", done, 4'b0000);
        checkOutput("wd_noerr", timeout_err, 1'b0);
        applyStimulus(4'b0000, 8'h00, 1'b0);
        checkOutput("wd_drop", grant, 4'b0000);

        // Asynchronous reset mid-HOLD clears the bus between clock edges
        doReset();
        applyStimulus(4'b0010, 8'h0C, 1'b0);
        checkOutput("ar_grant", grant, 4'b0010);
        checkOutput("ar_bus", bus_out, 4'b0111);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_grant0", grant, 4'b0000);
        checkOutput("ar_valid0", bus_valid, 1'b0);
        checkOutput("ar_bus0", bus_out, 4'b0000);
        checkOutput("ar_done0", done, 4'b0000);
        @(negedge clock50);
        reset = 1'b0;

        // rr_ptr=3 with nodes 0 and 3 requesting
        applyStimulus(4'b0100, 8'h00, 1'b0);
        applyStimulus(4'b0100, 8'h00, 1'b1);
        applyStimulus(4'b0000, 8'h00, 1'b0);
        checkOutput("pr_rr", rr_ptr_dbg, 2'd3);
        applyStimulus(4'b1001, 8'h00, 1'b0);
`ifdef ARB_PRIORITY_EN
        checkOutput("pr_grant", grant, 4'b0001);
`else
        checkOutput("pr_grant", grant, 4'b1000);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
